// File: rtl/accel_avg_filter.sv
// Boxcar moving average over the last 2^LOG2_DEPTH X/Y accelerometer samples, feeding the CORDIC stage.
// Define ACCEL_AVG_ROUND_EN to round half toward +inf (saturated) instead of flooring the average.
module accel_avg_axis #(
  parameter int N          = 10,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  acc,
  input  logic                  upd,
  input  logic [LOG2_DEPTH-1:0] wptr,
  input  logic signed [N-1:0]   sample,
  output logic signed [N-1:0]   avg
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = N + LOG2_DEPTH;

  logic signed [N-1:0]  hist [DEPTH];
  logic signed [SW-1:0] sum, sum_nxt;
  logic signed [N-1:0]  avg_nxt;

  // Oldest sample leaves the window as the new one enters at wptr
  always_comb sum_nxt = sum + SW'(sample) - SW'(hist[wptr]);

`ifdef ACCEL_AVG_ROUND_EN
  localparam logic signed [SW:0] MAXV = (SW+1)'((1 << (N-1)) - 1);
  logic signed [SW:0] rnd, shf;
  always_comb begin
    rnd     = {sum_nxt[SW-1], sum_nxt} + (SW+1)'(1 << (LOG2_DEPTH-1));
    shf     = rnd >>> LOG2_DEPTH;
    avg_nxt = (shf > MAXV) ? MAXV[N-1:0] : shf[N-1:0];
  end
`else
  always_comb avg_nxt = sum_nxt[SW-1:LOG2_DEPTH];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      sum <= '0;
      avg <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      sum <= '0;
    end else if (acc) begin
      hist[wptr] <= sample;
      sum        <= sum_nxt;
      if (upd) avg <= avg_nxt;
    end
  end
endmodule

module accel_avg_filter #(
  parameter int N          = 10,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic signed [N-1:0] i_xval,
  input  logic signed [N-1:0] i_yval,
  input  logic                i_flush,
  output logic signed [N-1:0] o_xval,
  output logic signed [N-1:0] o_yval,
  output logic                o_valid,
  output logic                o_filled
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FULL = (LOG2_DEPTH+1)'(DEPTH);

  logic [LOG2_DEPTH-1:0] wptr;
  logic [LOG2_DEPTH:0]   fill, fill_nxt;
  logic                  acc, upd;
  logic [1:0][N-1:0]     smp, avg;

  assign acc      = i_valid & ~i_flush;
  assign fill_nxt = (fill == FULL) ? FULL : fill + 1'b1;
  assign upd      = acc & (fill_nxt == FULL);
  assign smp      = {i_yval, i_xval};
  assign o_xval   = avg[0];
  assign o_yval   = avg[1];

  for (genvar g = 0; g < 2; g++) begin : g_axis
    accel_avg_axis #(.N(N), .LOG2_DEPTH(LOG2_DEPTH)) u_axis (
      .clk   (i_clk),
      .rst   (i_rst),
      .clr   (i_flush),
      .acc   (acc),
      .upd   (upd),
      .wptr  (wptr),
      .sample(smp[g]),
      .avg   (avg[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wptr     <= '0;
      fill     <= '0;
      o_valid  <= 1'b0;
      o_filled <= 1'b0;
    end else if (i_valid) begin
      wptr     <= wptr + 1'b1;
      fill     <= fill_nxt;
      o_valid  <= upd;
      o_filled <= o_filled | upd;
    end else begin
      o_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_accel_avg_filter.sv
// Randomized and directed checks of accel_avg_filter against a queue-based window-average model.
module tb_accel_avg_filter;
  localparam int N     = 10;
  localparam int L     = 3;
  localparam int DEPTH = 1 << L;
  localparam int MAXV  = (1 << (N-1)) - 1;
  localparam int MINV  = -(1 << (N-1));

  logic clk = 0;
  logic i_rst = 0, i_valid = 0, i_flush = 0;
  logic signed [N-1:0] i_xval = '0, i_yval = '0;
  logic signed [N-1:0] o_xval, o_yval;
  logic o_valid, o_filled;

  int checks = 0, failures = 0;

  // model state: window contents since last clear, expected outputs
  int qx[$], qy[$];
  int ex = 0, ey = 0;
  logic ev = 0, ef = 0;

  accel_avg_filter #(.N(N), .LOG2_DEPTH(L)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_xval(i_xval), .i_yval(i_yval),
    .i_flush(i_flush), .o_xval(o_xval), .o_yval(o_yval), .o_valid(o_valid), .o_filled(o_filled)
  );

  always #5 clk = ~clk;

  function automatic int wavg(input int q[$]);
    int s = 0;
    int r;
    foreach (q[i]) s += q[i];
`ifdef ACCEL_AVG_ROUND_EN
    s += DEPTH / 2;
`endif
    r = s / DEPTH;
    if ((s % DEPTH) != 0 && s < 0) r--;
    if (r > MAXV) r = MAXV;
    if (r < MINV) r = MINV;
    return r;
  endfunction

  // Drive one cycle of inputs and advance the model; returns #1 after the edge.
  task automatic cyc(input logic v, input logic f, input logic r, input int x, input int y);
    @(negedge clk);
    i_valid = v; i_flush = f; i_rst = r;
    i_xval = x[N-1:0]; i_yval = y[N-1:0];
    if (r) begin
      qx.delete(); qy.delete(); ex = 0; ey = 0; ev = 0; ef = 0;
    end else if (f) begin
      qx.delete(); qy.delete(); ev = 0; ef = 0;
    end else if (v) begin
      qx.push_back(x); qy.push_back(y);
      if (qx.size() > DEPTH) begin void'(qx.pop_front()); void'(qy.pop_front()); end
      ev = (qx.size() == DEPTH);
      if (ev) begin ef = 1; ex = wavg(qx); ey = wavg(qy); end
    end else begin
      ev = 0;
    end
    @(posedge clk); #1;
    i_valid = 0; i_flush = 0; i_rst = 0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 1, 123, -45);
    checks += 4;
    if (o_xval !== '0)   begin failures++; $display("FAIL reset_x got=%0d want=0", o_xval); end
    if (o_yval !== '0)   begin failures++; $display("FAIL reset_y got=%0d want=0", o_yval); end
    if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    if (o_filled !== 1'b0) begin failures++; $display("FAIL reset_filled got=%b want=0", o_filled); end
  endtask

  task automatic test_warmup();
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, 0, 100, -50);
      checks += 2;
      if (o_valid !== (i == DEPTH-1)) begin failures++; $display("FAIL warm_valid i=%0d got=%b", i, o_valid); end
      if (o_filled !== (i == DEPTH-1)) begin failures++; $display("FAIL warm_filled i=%0d got=%b", i, o_filled); end
      if (i < DEPTH-1) begin
        checks++;
        if (o_xval !== '0) begin failures++; $display("FAIL warm_hold i=%0d got=%0d want=0", i, o_xval); end
      end
    end
    checks += 2;
    if (o_xval !== N'(100)) begin failures++; $display("FAIL warm_x got=%0d want=100", o_xval); end
    if (o_yval !== N'(-50)) begin failures++; $display("FAIL warm_y got=%0d want=-50", o_yval); end
    cyc(0, 0, 0, 0, 0);
    checks += 2;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL warm_pulse got=%b want=0", o_valid); end
    if (o_filled !== 1'b1) begin failures++; $display("FAIL warm_filled_hold got=%b want=1", o_filled); end
  endtask

  task automatic test_step();
    int want[DEPTH] = '{75, 50, 25, 0, -25, -50, -75, -100};
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 100, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, 0, -100, 0);
      checks += 3;
      if (o_valid !== 1'b1) begin failures++; $display("FAIL step_valid i=%0d got=%b", i, o_valid); end
      if (o_xval !== N'(want[i])) begin failures++; $display("FAIL step_x i=%0d got=%0d want=%0d", i, o_xval, want[i]); end
      if (o_yval !== '0) begin failures++; $display("FAIL step_y i=%0d got=%0d want=0", i, o_yval); end
    end
  endtask

  task automatic test_rounding();
    int wp, wn;
`ifdef ACCEL_AVG_ROUND_EN
    wp = 1; wn = -1;
`else
    wp = 0; wn = -1;
`endif
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH-1; i++) cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (o_xval !== N'(wp)) begin failures++; $display("FAIL round_pos got=%0d want=%0d", o_xval, wp); end
    for (int i = 0; i < DEPTH-1; i++) cyc(1, 0, 0, -1, 0);
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (o_xval !== N'(wn)) begin failures++; $display("FAIL round_neg got=%0d want=%0d", o_xval, wn); end
  endtask

  task automatic test_extremes();
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, MINV, MAXV);
    checks += 2;
    if (o_xval !== N'(MINV)) begin failures++; $display("FAIL ext_x got=%0d want=%0d", o_xval, MINV); end
    if (o_yval !== N'(MAXV)) begin failures++; $display("FAIL ext_y got=%0d want=%0d", o_yval, MAXV); end
  endtask

  task automatic test_flush();
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 100, -50);
    cyc(1, 1, 0, 300, 300);
    checks += 4;
    if (o_valid !== 1'b0)   begin failures++; $display("FAIL flush_valid got=%b want=0", o_valid); end
    if (o_filled !== 1'b0)  begin failures++; $display("FAIL flush_filled got=%b want=0", o_filled); end
    if (o_xval !== N'(100)) begin failures++; $display("FAIL flush_hold_x got=%0d want=100", o_xval); end
    if (o_yval !== N'(-50)) begin failures++; $display("FAIL flush_hold_y got=%0d want=-50", o_yval); end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, 0, 20, 20);
      checks++;
      if (o_valid !== (i == DEPTH-1)) begin failures++; $display("FAIL flush_refill i=%0d got=%b", i, o_valid); end
    end
    checks++;
    if (o_xval !== N'(20)) begin failures++; $display("FAIL flush_first got=%0d want=20", o_xval); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 40 + i, -7);
    cyc(1, 0, 1, 77, 77);
    checks += 3;
    if (o_xval !== '0 || o_yval !== '0) begin failures++; $display("FAIL rmid_out got=%0d,%0d want=0,0", o_xval, o_yval); end
    if (o_filled !== 1'b0) begin failures++; $display("FAIL rmid_filled got=%b want=0", o_filled); end
    if (o_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b want=0", o_valid); end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, 0, 8 * i, -3 * i);
      checks += 2;
      if (o_valid !== ev) begin failures++; $display("FAIL rmid_refill i=%0d got=%b want=%b", i, o_valid, ev); end
      if (o_xval !== N'(ex)) begin failures++; $display("FAIL rmid_x i=%0d got=%0d want=%0d", i, o_xval, ex); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic v, f, r;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 149) == 0);
      cyc(v, f, r, int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512);
      checks++;
      if (o_valid !== ev || o_filled !== ef || o_xval !== N'(ex) || o_yval !== N'(ey)) begin
        failures++;
        $display("FAIL rand i=%0d got v=%b f=%b x=%0d y=%0d want v=%b f=%b x=%0d y=%0d",
                 i, o_valid, o_filled, o_xval, o_yval, ev, ef, ex, ey);
      end
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_step();
    test_rounding();
    test_extremes();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
